// File: rtl/arm_pkg.sv
// Purpose: shared ARM execute-path constants, operand-2 field positions and the decoded result type.
// Latency: n/a (declarations and one pure combinational helper).
// Backpressure: n/a.
package arm_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // Shifter type encoding, as consumed by the barrel shifter Type input.
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Operand-2 field positions within instruction bits [11:0].
    localparam int OP2_IMM8_LSB   = 0;
    localparam int OP2_IMM8_MSB   = 7;
    localparam int OP2_ROT_LSB    = 8;
    localparam int OP2_ROT_MSB    = 11;
    localparam int OP2_SHAMT_LSB  = 7;
    localparam int OP2_SHAMT_MSB  = 11;
    localparam int OP2_SHTYPE_LSB = 5;
    localparam int OP2_SHTYPE_MSB = 6;
    localparam int OP2_REGSH_BIT  = 4;

    // Everything the stage registers toward the shifter and the bypass mux.
    typedef struct packed {
        logic [AMT_W-1:0]  amount;
        logic [1:0]        sh_type;
        logic [DATA_W-1:0] sh_in;
        logic              byp_en;
        logic [DATA_W-1:0] byp_val;
        logic              carry;
    } op2_res_t;

    // Carry-out of a real shift by n in 1..31: LSL takes the last bit shifted
    // out at the top (val[32-n], i.e. index -n mod 32), the right shifts and
    // rotate take the last bit shifted out at the bottom (val[n-1]).
    function automatic logic shift_carry(input logic [DATA_W-1:0] val,
                                         input logic [1:0]        t,
                                         input logic [AMT_W-1:0]  n);
        logic [AMT_W-1:0] idx;
        if (t == SH_LSL) begin
            idx = 5'd0 - n;
        end else begin
            idx = n - 5'd1;
        end
        return val[idx];
    endfunction

endpackage

// File: rtl/operand2_decode.sv
// Purpose: combinational ARM operand-2 decode into shifter controls, bypass value and carry-out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the wrapping stage decides when the result is captured.
// Ports: i_imm_form (instr bit 25), i_op2 (instr [11:0]), i_rm / i_rs (Rm and Rs[7:0]),
//        i_carry (CPSR.C) -> o_res (amount, type, shifter input, bypass enable/value, carry).
module operand2_decode
    import arm_pkg::*;
(
    input  logic              i_imm_form,
    input  logic [11:0]       i_op2,
    input  logic [DATA_W-1:0] i_rm,
    input  logic [7:0]        i_rs,
    input  logic              i_carry,
    output op2_res_t          o_res
);

    logic [3:0]        w_rot;
    logic [AMT_W-1:0]  w_rot_amt;
    logic [DATA_W-1:0] w_imm32;
    logic [AMT_W-1:0]  w_n;
    logic [1:0]        w_t;
    logic              w_reg_shift;

    assign w_rot       = i_op2[OP2_ROT_MSB:OP2_ROT_LSB];
    assign w_rot_amt   = {w_rot, 1'b0};
    assign w_imm32     = {{(DATA_W-8){1'b0}}, i_op2[OP2_IMM8_MSB:OP2_IMM8_LSB]};
    assign w_n         = i_op2[OP2_SHAMT_MSB:OP2_SHAMT_LSB];
    assign w_t         = i_op2[OP2_SHTYPE_MSB:OP2_SHTYPE_LSB];
    assign w_reg_shift = i_op2[OP2_REGSH_BIT];

    always_comb begin
        // Defaults double as the bypass shape: shifter gets Rm, LSL #0.
        o_res         = '0;
        o_res.sh_in   = i_rm;
        o_res.sh_type = SH_LSL;
        o_res.amount  = '0;
        o_res.carry   = i_carry;

        if (i_imm_form) begin
            o_res.sh_in   = w_imm32;
            o_res.sh_type = SH_ROR;
            o_res.amount  = w_rot_amt;
            // Bit 31 of a right rotate by r is bit r-1 of the source.
            if (w_rot != 4'd0) begin
                o_res.carry = shift_carry(w_imm32, SH_ROR, w_rot_amt);
            end
        end else if (!w_reg_shift) begin
            if (w_n != '0) begin
                o_res.sh_type = w_t;
                o_res.amount  = w_n;
                o_res.carry   = shift_carry(i_rm, w_t, w_n);
            end else begin
                // A zero immediate encodes LSR #32, ASR #32 or RRX for the
                // non-LSL types; none of these fits a 5-bit amount.
                case (w_t)
                    SH_LSL: begin
                        o_res.carry = i_carry;
                    end
                    SH_LSR: begin
                        o_res.byp_en = 1'b1;
                        o_res.carry  = i_rm[DATA_W-1];
                    end
                    SH_ASR: begin
                        o_res.byp_en  = 1'b1;
                        o_res.byp_val = {DATA_W{i_rm[DATA_W-1]}};
                        o_res.carry   = i_rm[DATA_W-1];
                    end
                    default: begin
                        o_res.byp_en  = 1'b1;
                        o_res.byp_val = {i_carry, i_rm[DATA_W-1:1]};
                        o_res.carry   = i_rm[0];
                    end
                endcase
            end
        end else begin
            if (i_rs == 8'd0) begin
                o_res.sh_type = w_t;
                o_res.carry   = i_carry;
            end else if (i_rs[7:5] == 3'd0) begin
                o_res.sh_type = w_t;
                o_res.amount  = i_rs[4:0];
                o_res.carry   = shift_carry(i_rm, w_t, i_rs[4:0]);
            end else begin
                // Amount of 32 or more.
                case (w_t)
                    SH_LSL: begin
                        o_res.byp_en = 1'b1;
                        o_res.carry  = (i_rs == 8'd32) ? i_rm[0] : 1'b0;
                    end
                    SH_LSR: begin
                        o_res.byp_en = 1'b1;
                        o_res.carry  = (i_rs == 8'd32) ? i_rm[DATA_W-1] : 1'b0;
                    end
                    SH_ASR: begin
                        o_res.byp_en  = 1'b1;
                        o_res.byp_val = {DATA_W{i_rm[DATA_W-1]}};
                        o_res.carry   = i_rm[DATA_W-1];
                    end
                    default: begin
                        // Rotation is modulo 32; a multiple of 32 leaves Rm intact
                        // but still reports bit 31 as the carry.
                        o_res.sh_type = SH_ROR;
                        o_res.amount  = i_rs[4:0];
                        if (i_rs[4:0] == 5'd0) begin
                            o_res.carry = i_rm[DATA_W-1];
                        end else begin
                            o_res.carry = shift_carry(i_rm, SH_ROR, i_rs[4:0]);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/operand2_stage.sv
// Purpose: registered operand-2 stage feeding the barrel shifter and the special-case bypass.
// Latency: 1 cycle from accepted input to Out_Valid.
// Backpressure: valid/ready; In_Ready = !Out_Valid | Out_Ready (full throughput), forced low by Flush.
// Ports: CLK/RESETn, Flush; In_Valid/In_Ready with I_Bit, Op2, Rm_Data, Rs_Data, Carry_In;
//        Out_Valid/Out_Ready with Sh_Amount, Sh_Type, Sh_In, Bypass_En, Bypass_Value, Carry_Out.
module operand2_stage
    import arm_pkg::op2_res_t;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic              I_Bit,
    input  logic [11:0]       Op2,
    input  logic [DATA_W-1:0] Rm_Data,
    input  logic [DATA_W-1:0] Rs_Data,
    input  logic              Carry_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [AMT_W-1:0]  Sh_Amount,
    output logic [1:0]        Sh_Type,
    output logic [DATA_W-1:0] Sh_In,
    output logic              Bypass_En,
    output logic [DATA_W-1:0] Bypass_Value,
    output logic              Carry_Out
);

    logic     w_in_ready;
    logic     w_load;
    logic     w_unused_rs_hi;
    op2_res_t w_dec;
    op2_res_t r_res;
    logic     r_out_valid;

    // Only Rs[7:0] takes part in a register-specified shift.
    assign w_unused_rs_hi = ^Rs_Data[DATA_W-1:8];

    assign w_in_ready = !Flush && (!r_out_valid || Out_Ready);
    assign w_load     = In_Valid && w_in_ready;

    operand2_decode u_decode (
        .i_imm_form (I_Bit),
        .i_op2      (Op2),
        .i_rm       (Rm_Data),
        .i_rs       (Rs_Data[7:0]),
        .i_carry    (Carry_In),
        .o_res      (w_dec)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else begin
            if (Flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (Out_Ready) begin
                r_out_valid <= 1'b0;
            end
            // w_load is already gated by Flush, so a flushed cycle never overwrites data.
            if (w_load) begin
                r_res <= w_dec;
            end
        end
    end

    assign In_Ready     = w_in_ready;
    assign Out_Valid    = r_out_valid;
    assign Sh_Amount    = r_res.amount;
    assign Sh_Type      = r_res.sh_type;
    assign Sh_In        = r_res.sh_in;
    assign Bypass_En    = r_res.byp_en;
    assign Bypass_Value = r_res.byp_val;
    assign Carry_Out    = r_res.carry;

endmodule

// File: tb/tb_operand2_stage.sv
module tb_operand2_stage;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        Flush;
    logic        In_Valid;
    logic        In_Ready;
    logic        I_Bit;
    logic [11:0] Op2;
    logic [31:0] Rm_Data;
    logic [31:0] Rs_Data;
    logic        Carry_In;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [4:0]  Sh_Amount;
    logic [1:0]  Sh_Type;
    logic [31:0] Sh_In;
    logic        Bypass_En;
    logic [31:0] Bypass_Value;
    logic        Carry_Out;

    int n_asserts = 0;
    int n_fail    = 0;

    operand2_stage #(.DATA_W(32), .AMT_W(5)) dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .Flush        (Flush),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .I_Bit        (I_Bit),
        .Op2          (Op2),
        .Rm_Data      (Rm_Data),
        .Rs_Data      (Rs_Data),
        .Carry_In     (Carry_In),
        .Out_Valid    (Out_Valid),
        .Out_Ready    (Out_Ready),
        .Sh_Amount    (Sh_Amount),
        .Sh_Type      (Sh_Type),
        .Sh_In        (Sh_In),
        .Bypass_En    (Bypass_En),
        .Bypass_Value (Bypass_Value),
        .Carry_Out    (Carry_Out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [4:0] amt, input logic [1:0] typ,
                           input logic [31:0] shin, input logic byp, input logic [31:0] bypv, input logic cy);
        chk(tag, "vld",  {31'd0, Out_Valid}, {31'd0, vld});
        chk(tag, "amt",  {27'd0, Sh_Amount}, {27'd0, amt});
        chk(tag, "typ",  {30'd0, Sh_Type},   {30'd0, typ});
        chk(tag, "shin", Sh_In, shin);
        chk(tag, "byp",  {31'd0, Bypass_En}, {31'd0, byp});
        chk(tag, "bypv", Bypass_Value, bypv);
        chk(tag, "cy",   {31'd0, Carry_Out}, {31'd0, cy});
    endtask

    // Present one entry for one cycle, then drop In_Valid.
    task automatic send(input logic ib, input logic [11:0] op, input logic [31:0] rm,
                        input logic [31:0] rs, input logic cin);
        I_Bit    = ib;
        Op2      = op;
        Rm_Data  = rm;
        Rs_Data  = rs;
        Carry_In = cin;
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
    endtask

    initial begin
        RESETn    = 1'b0;
        Flush     = 1'b0;
        In_Valid  = 1'b0;
        I_Bit     = 1'b0;
        Op2       = 12'h000;
        Rm_Data   = 32'h0;
        Rs_Data   = 32'h0;
        Carry_In  = 1'b0;
        Out_Ready = 1'b1;
        #2;
        chk_out("reset", 1'b0, 5'd0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("reset", "in_rdy", {31'd0, In_Ready}, 32'd1);
        #1;
        RESETn = 1'b1;
        tick();

        // Rotated immediate 0xFF ror 8 -> 0xFF000000, carry = bit 31.
        send(1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0);
        chk_out("imm_rot8", 1'b1, 5'd8, 2'b11, 32'h0000_00FF, 1'b0, 32'h0, 1'b1);
        // rot = 0 keeps CPSR.C.
        send(1'b1, 12'h0AB, 32'h0, 32'h0, 1'b1);
        chk_out("imm_rot0", 1'b1, 5'd0, 2'b11, 32'h0000_00AB, 1'b0, 32'h0, 1'b1);
        // LSR #0 == LSR #32.
        send(1'b0, 12'h020, 32'h8000_0001, 32'h0, 1'b0);
        chk_out("lsr32", 1'b1, 5'd0, 2'b00, 32'h8000_0001, 1'b1, 32'h0, 1'b1);
        // ROR #0 == RRX.
        send(1'b0, 12'h060, 32'h8000_0001, 32'h0, 1'b1);
        chk_out("rrx", 1'b1, 5'd0, 2'b00, 32'h8000_0001, 1'b1, 32'hC000_0000, 1'b1);
        // ASR #0 == ASR #32 with negative Rm.
        send(1'b0, 12'h040, 32'h8000_0000, 32'h0, 1'b0);
        chk_out("asr32", 1'b1, 5'd0, 2'b00, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1);
        // LSL #4: carry = Rm[28].
        send(1'b0, 12'h200, 32'h1000_0000, 32'h0, 1'b0);
        chk_out("lsl4", 1'b1, 5'd4, 2'b00, 32'h1000_0000, 1'b0, 32'h0, 1'b1);
        // Register LSL by 32, 33, and 0 (Rs=0x100 -> s=0).
        send(1'b0, 12'h010, 32'h0000_0001, 32'h20, 1'b0);
        chk_out("rlsl32", 1'b1, 5'd0, 2'b00, 32'h0000_0001, 1'b1, 32'h0, 1'b1);
        send(1'b0, 12'h010, 32'h0000_0001, 32'h21, 1'b1);
        chk_out("rlsl33", 1'b1, 5'd0, 2'b00, 32'h0000_0001, 1'b1, 32'h0, 1'b0);
        send(1'b0, 12'h010, 32'h0000_0001, 32'h100, 1'b1);
        chk_out("rlsl0", 1'b1, 5'd0, 2'b00, 32'h0000_0001, 1'b0, 32'h0, 1'b1);
        // Register LSR by 3: carry = Rm[2].
        send(1'b0, 12'h030, 32'h0000_0004, 32'h3, 1'b0);
        chk_out("rlsr3", 1'b1, 5'd3, 2'b01, 32'h0000_0004, 1'b0, 32'h0, 1'b1);
        // Register ROR by 64 -> amount 0, carry = Rm[31].
        send(1'b0, 12'h070, 32'h8000_0000, 32'h40, 1'b0);
        chk_out("rror64", 1'b1, 5'd0, 2'b11, 32'h8000_0000, 1'b0, 32'h0, 1'b1);
        // Register ROR by 36 -> amount 4, carry = Rm[3].
        send(1'b0, 12'h070, 32'h0000_0008, 32'h24, 1'b0);
        chk_out("rror36", 1'b1, 5'd4, 2'b11, 32'h0000_0008, 1'b0, 32'h0, 1'b1);

        // Drain, then backpressure with two back-to-back entries.
        tick();
        chk("drain", "vld", {31'd0, Out_Valid}, 32'd0);
        Out_Ready = 1'b0;
        send(1'b1, 12'h011, 32'h0, 32'h0, 1'b0);
        I_Bit    = 1'b1;
        Op2      = 12'h022;
        In_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", "in_rdy", {31'd0, In_Ready}, 32'd0);
            chk_out("bp_hold", 1'b1, 5'd0, 2'b11, 32'h11, 1'b0, 32'h0, 1'b0);
            tick();
        end
        Out_Ready = 1'b1;
        #1;
        chk("bp_release", "in_rdy", {31'd0, In_Ready}, 32'd1);
        tick();
        In_Valid = 1'b0;
        chk_out("bp_second", 1'b1, 5'd0, 2'b11, 32'h22, 1'b0, 32'h0, 1'b0);
        tick();
        chk("bp_empty", "vld", {31'd0, Out_Valid}, 32'd0);

        // Flush while full, with a new entry offered and downstream ready.
        Out_Ready = 1'b0;
        send(1'b1, 12'h033, 32'h0, 32'h0, 1'b0);
        chk_out("pre_flush", 1'b1, 5'd0, 2'b11, 32'h33, 1'b0, 32'h0, 1'b0);
        Out_Ready = 1'b1;
        Flush     = 1'b1;
        I_Bit     = 1'b1;
        Op2       = 12'h044;
        In_Valid  = 1'b1;
        #1;
        chk("flush", "in_rdy", {31'd0, In_Ready}, 32'd0);
        tick();
        Flush    = 1'b0;
        In_Valid = 1'b0;
        chk("flush", "vld", {31'd0, Out_Valid}, 32'd0);
        chk("flush", "shin", Sh_In, 32'h33);

        // Asynchronous reset mid-transfer.
        send(1'b1, 12'h055, 32'h0, 32'h0, 1'b1);
        chk("pre_rst", "vld", {31'd0, Out_Valid}, 32'd1);
        #2;
        RESETn = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 5'd0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        RESETn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
